// File: rtl/rng_sched.sv
// rng_sched: round-robin scheduler sharing one 16-bit Fibonacci LFSR among
// NREQ requesters. Owns seeding and warm-up of the generator; each grant
// delivers the current LFSR word and steps the LFSR once.
// Optional feature: define RNG_SCHED_RESEED_EN to add the seed_load port,
// which reloads the LFSR and restarts warm-up without a full reset.
module rng_sched #(
    parameter int NREQ   = 4,   // number of requesters, 2..16
    parameter int WARMUP = 16   // free-running LFSR steps after seeding, 0..255
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [15:0]     seed,
`ifdef RNG_SCHED_RESEED_EN
    input  logic            seed_load,
`endif
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [15:0]     rnd,
    output logic            rnd_valid,
    output logic            ready
);

    localparam int PW = $clog2(NREQ);
    localparam int IW = PW + 1;

    typedef enum logic {
        ST_WARM,
        ST_RUN
    } state_t;

    // With no warm-up the block comes out of reset already serving.
    localparam state_t     RESET_STATE = (WARMUP == 0) ? ST_RUN : ST_WARM;
    localparam logic [7:0] WARM_LAST   = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

    // One Fibonacci step, taps 15/12/5/0.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[12] ^ s[5] ^ s[0]};
    endfunction

    // The all-zero state never leaves zero, so it is replaced on load.
    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0000) ? 16'hACE1 : s;
    endfunction

    state_t          r_state;
    logic [15:0]     r_lfsr;
    logic [7:0]      r_warm_cnt;
    logic [PW-1:0]   r_ptr;
    logic [NREQ-1:0] r_gnt;
    logic [15:0]     r_rnd;
    logic            r_rnd_valid;

    logic            w_win;
    logic [PW-1:0]   w_win_idx;
    logic [PW-1:0]   w_ptr_next;
    logic [IW-1:0]   w_idx;
    logic [NREQ-1:0] w_gnt;

    // Round-robin search: first requesting index at or after r_ptr, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
        w_win     = 1'b0;
        w_win_idx = '0;
        w_idx     = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = IW'(r_ptr) + IW'(i);
            if (w_idx >= IW'(NREQ)) begin
                w_idx = w_idx - IW'(NREQ);
            end
            if (!w_win && req[w_idx[PW-1:0]]) begin
                w_win     = 1'b1;
                w_win_idx = w_idx[PW-1:0];
            end
        end
    end

    // Grant vector and pointer advance derived from the winner.
    always_comb begin
        w_gnt      = '0;
        w_gnt[w_win_idx] = w_win;
        w_ptr_next = (w_win_idx == PW'(NREQ - 1)) ? '0 : w_win_idx + PW'(1);
    end

    // State machine, LFSR, pointer and registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!resetn) begin
            r_state     <= RESET_STATE;
            r_lfsr      <= seed_fix(seed);
            r_warm_cnt  <= '0;
            r_ptr       <= '0;
            r_gnt       <= '0;
            r_rnd       <= '0;
            r_rnd_valid <= 1'b0;
        end
`ifdef RNG_SCHED_RESEED_EN
        else if (seed_load) begin
            // Reseed wins over arbitration; the pointer survives so fairness carries over.
            r_state     <= RESET_STATE;
            r_lfsr      <= seed_fix(seed);
            r_warm_cnt  <= '0;
            r_gnt       <= '0;
            r_rnd_valid <= 1'b0;
        end
`endif
        else begin
            case (r_state)
                ST_WARM: begin
                    r_lfsr      <= lfsr_next(r_lfsr);
                    r_gnt       <= '0;
                    r_rnd_valid <= 1'b0;
                    if (r_warm_cnt == WARM_LAST) begin
                        r_state    <= ST_RUN;
                        r_warm_cnt <= '0;
                    end else begin
                        r_warm_cnt <= r_warm_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    if (w_win) begin
                        r_gnt       <= w_gnt;
                        r_rnd       <= r_lfsr;
                        r_rnd_valid <= 1'b1;
                        r_lfsr      <= lfsr_next(r_lfsr);
                        r_ptr       <= w_ptr_next;
                    end else begin
                        r_gnt       <= '0;
                        r_rnd_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= RESET_STATE;
                end
            endcase
        end
    end

    assign gnt       = r_gnt;
    assign rnd       = r_rnd;
    assign rnd_valid = r_rnd_valid;
    assign ready     = (r_state == ST_RUN);

endmodule
